// File: rtl/subc_pkg.sv
// subc_pkg: shared types and helpers for the subcarrier extractor
package subc_pkg;

    typedef enum logic [1:0] {SC_NULL, SC_DATA, SC_PILOT, SC_RSVD} subc_type_t;

    typedef enum logic {S_IDLE, S_OPEN} sym_state_t;

    // framing and symbol parameters of one data carrier; I/Q sit above this in the FIFO word
    typedef struct packed {
        logic       sos;
        logic       eos;
        logic       sof;
        logic [2:0] m;
        logic [3:0] ss;
    } dat_entry_t;

    localparam int META_W = $bits(dat_entry_t);

    function automatic int dat_entry_w(input int dw);
        return 2 * dw + META_W;
    endfunction

endpackage

// File: rtl/subc_extractor_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO, simultaneous push/pop allowed even when full
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // storage array, written without reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt    <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/subc_extractor.sv
// subc_extractor: sorts demapper carriers into pilot port, data FIFO and per-symbol counts
module subc_extractor
    import subc_pkg::*;
#(
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ival,
    input  logic             isop,
    input  logic             isof,
    input  logic [DW-1:0]    isubc_i,
    input  logic [DW-1:0]    isubc_q,
    input  logic [1:0]       iindex_subc,
    input  logic [2:0]       iindex_M,
    input  logic [3:0]       iindex_ss,
    output logic             odat_val,
    input  logic             odat_rdy,
    output logic [DW-1:0]    odat_i,
    output logic [DW-1:0]    odat_q,
    output logic             odat_sos,
    output logic             odat_eos,
    output logic             odat_sof,
    output logic [2:0]       odat_M,
    output logic [3:0]       odat_ss,
    output logic             opil_val,
    output logic [DW-1:0]    opil_i,
    output logic [DW-1:0]    opil_q,
    output logic [CNT_W-1:0] opil_idx,
    output logic             osym_done,
    output logic [CNT_W-1:0] odata_cnt,
    output logic [CNT_W-1:0] opil_cnt,
    output logic             oovf
);
    localparam int               EW      = dat_entry_w(DW);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sym_state_t       state;
    subc_type_t       ctype;
    logic             start, close, acc, is_dat, is_pil;
    logic [CNT_W-1:0] dcnt, pcnt;
    logic             sof_r;
    logic [2:0]       m_r;
    logic [3:0]       ss_r;
    logic             hold_v;
    logic [DW-1:0]    hold_i, hold_q;
    dat_entry_t       hold_e, wr_e, rd_e;
    logic             wr_en, full, empty, pop;
    logic [EW-1:0]    wr_data, rd_data;

    assign ctype  = subc_type_t'(iindex_subc);
    assign start  = ival & isop;
    assign close  = (state == S_OPEN) & (start | ~ival);
    assign acc    = ival & ((state == S_OPEN) | isop);
    assign is_dat = acc & (ctype == SC_DATA);
    assign is_pil = acc & (ctype == SC_PILOT);

    // the held carrier leaves when displaced by a newer one, or tagged eos when its symbol closes
    assign wr_en = hold_v & (close | is_dat);

    // eos is decided at write time, not when the carrier is captured
    always_comb begin
        wr_e     = hold_e;
        wr_e.eos = close;
    end

    assign wr_data = {hold_i, hold_q, wr_e};
    assign pop     = odat_rdy & ~empty;

    sync_fifo_fwft #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (pop),
        .dout  (rd_data),
        .full  (full),
        .empty (empty)
    );

    // head fields are forced to zero while the FIFO is empty so stale RAM never shows
    assign rd_e     = empty ? '0 : dat_entry_t'(rd_data[META_W-1:0]);
    assign odat_val = ~empty;
    assign odat_i   = empty ? '0 : rd_data[EW-1 -: DW];
    assign odat_q   = empty ? '0 : rd_data[EW-DW-1 -: DW];
    assign odat_sos = rd_e.sos;
    assign odat_eos = rd_e.eos;
    assign odat_sof = rd_e.sof;
    assign odat_M   = rd_e.m;
    assign odat_ss  = rd_e.ss;

    // symbol FSM: latch symbol parameters, count carriers, report counts the cycle after close
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sof_r     <= 1'b0;
            m_r       <= '0;
            ss_r      <= '0;
            dcnt      <= '0;
            pcnt      <= '0;
            osym_done <= 1'b0;
            odata_cnt <= '0;
            opil_cnt  <= '0;
        end else begin
            osym_done <= close;
            if (close) begin
                odata_cnt <= dcnt;
                opil_cnt  <= pcnt;
            end
            if (start) begin
                state <= S_OPEN;
                sof_r <= isof;
                m_r   <= iindex_M;
                ss_r  <= iindex_ss;
                dcnt  <= CNT_W'(is_dat);
                pcnt  <= CNT_W'(is_pil);
            end else begin
                if (close) state <= S_IDLE;
                if (is_dat && dcnt != CNT_MAX) dcnt <= dcnt + 1'b1;
                if (is_pil && pcnt != CNT_MAX) pcnt <= pcnt + 1'b1;
            end
        end
    end

    // one-entry hold register delays each data carrier until we know whether it ends the symbol
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
            hold_i <= '0;
            hold_q <= '0;
            hold_e <= '0;
        end else if (is_dat) begin
            hold_v <= 1'b1;
            hold_i <= isubc_i;
            hold_q <= isubc_q;
            hold_e <= '{sos: start | (dcnt == '0), eos: 1'b0,
                        sof: start ? isof : sof_r,
                        m:   start ? iindex_M : m_r,
                        ss:  start ? iindex_ss : ss_r};
        end else if (close) begin
            hold_v <= 1'b0;
        end
    end

    // pilot port: registered, one-cycle latency, ordinal restarts at each symbol
    always_ff @(posedge clk) begin
        if (rst) begin
            opil_val <= 1'b0;
            opil_i   <= '0;
            opil_q   <= '0;
            opil_idx <= '0;
        end else begin
            opil_val <= is_pil;
            if (is_pil) begin
                opil_i   <= isubc_i;
                opil_q   <= isubc_q;
                opil_idx <= start ? '0 : pcnt;
            end
        end
    end

    // sticky overflow: a write arrived while full and no pop freed a slot
    always_ff @(posedge clk) begin
        if (rst) oovf <= 1'b0;
        else if (wr_en & full & ~pop) oovf <= 1'b1;
    end

endmodule

// File: tb/tb_subc_extractor.sv
// tb_subc_extractor: scoreboard bench for the subcarrier extractor
module tb_subc_extractor;
    import subc_pkg::*;

    localparam int DW = 12, CNT_W = 11, EW = 2 * DW + 10;

    logic clk = 0, rst = 1, ival = 0, isop = 0, isof = 0;
    logic [DW-1:0] isubc_i = '0, isubc_q = '0;
    logic [1:0] iindex_subc = '0;
    logic [2:0] iindex_M = '0;
    logic [3:0] iindex_ss = '0;
    logic odat_rdy = 1, rdy8 = 1;

    logic odat_val, odat_sos, odat_eos, odat_sof, opil_val, osym_done, oovf;
    logic [DW-1:0] odat_i, odat_q, opil_i, opil_q;
    logic [2:0] odat_M;
    logic [3:0] odat_ss;
    logic [CNT_W-1:0] opil_idx, odata_cnt, opil_cnt;

    logic odat_val8, odat_sos8, odat_eos8, odat_sof8, opil_val8, osym_done8, oovf8;
    logic [DW-1:0] odat_i8, odat_q8, opil_i8, opil_q8;
    logic [2:0] odat_M8;
    logic [3:0] odat_ss8;
    logic [CNT_W-1:0] opil_idx8, odata_cnt8, opil_cnt8;

    subc_extractor #(.DW(DW), .FIFO_DEPTH(1024), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ival(ival), .isop(isop), .isof(isof),
        .isubc_i(isubc_i), .isubc_q(isubc_q), .iindex_subc(iindex_subc),
        .iindex_M(iindex_M), .iindex_ss(iindex_ss),
        .odat_val(odat_val), .odat_rdy(odat_rdy), .odat_i(odat_i), .odat_q(odat_q),
        .odat_sos(odat_sos), .odat_eos(odat_eos), .odat_sof(odat_sof),
        .odat_M(odat_M), .odat_ss(odat_ss),
        .opil_val(opil_val), .opil_i(opil_i), .opil_q(opil_q), .opil_idx(opil_idx),
        .osym_done(osym_done), .odata_cnt(odata_cnt), .opil_cnt(opil_cnt), .oovf(oovf)
    );

    subc_extractor #(.DW(DW), .FIFO_DEPTH(8), .CNT_W(CNT_W)) dut8 (
        .clk(clk), .rst(rst), .ival(ival), .isop(isop), .isof(isof),
        .isubc_i(isubc_i), .isubc_q(isubc_q), .iindex_subc(iindex_subc),
        .iindex_M(iindex_M), .iindex_ss(iindex_ss),
        .odat_val(odat_val8), .odat_rdy(rdy8), .odat_i(odat_i8), .odat_q(odat_q8),
        .odat_sos(odat_sos8), .odat_eos(odat_eos8), .odat_sof(odat_sof8),
        .odat_M(odat_M8), .odat_ss(odat_ss8),
        .opil_val(opil_val8), .opil_i(opil_i8), .opil_q(opil_q8), .opil_idx(opil_idx8),
        .osym_done(osym_done8), .odata_cnt(odata_cnt8), .opil_cnt(opil_cnt8), .oovf(oovf8)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    bit rnd_rdy = 0;
    logic [EW-1:0] exp_dat[$], sym_dat[$], ed;
    logic [2*DW+CNT_W-1:0] exp_pil[$], ep;
    logic [2*CNT_W-1:0] exp_sym[$], es;
    logic [1:0] ty[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: pop expected items as the DUT produces them
    always @(negedge clk) begin
        if (!rst) begin
            if (odat_val && odat_rdy) begin
                ed = exp_dat.size() ? exp_dat.pop_front() : 'x;
                chk("dat", {odat_i, odat_q, odat_sos, odat_eos, odat_sof, odat_M, odat_ss}, ed);
            end
            if (opil_val) begin
                ep = exp_pil.size() ? exp_pil.pop_front() : 'x;
                chk("pil", {opil_i, opil_q, opil_idx}, ep);
            end
            if (osym_done) begin
                es = exp_sym.size() ? exp_sym.pop_front() : 'x;
                chk("sym", {odata_cnt, opil_cnt}, es);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) odat_rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    // drive one symbol with the types in ty; expectations are pushed before driving
    task automatic send_sym(input bit sof, input logic [2:0] m, input logic [3:0] ss, input bit gap);
        logic [DW-1:0] ci[$], cq[$];
        logic [EW-1:0] e;
        int nd = 0, np = 0, first = -1, last = -1;
        for (int k = 0; k < ty.size(); k++) begin
            ci.push_back(DW'($urandom));
            cq.push_back(DW'($urandom));
            if (ty[k] == 2'd1) begin
                if (first < 0) first = k;
                last = k;
            end
        end
        sym_dat.delete();
        for (int k = 0; k < ty.size(); k++) begin
            if (ty[k] == 2'd1) begin
                e = {ci[k], cq[k], k == first, k == last, sof, m, ss};
                sym_dat.push_back(e);
                exp_dat.push_back(e);
                nd++;
            end else if (ty[k] == 2'd2) begin
                exp_pil.push_back({ci[k], cq[k], CNT_W'(np)});
                np++;
            end
        end
        exp_sym.push_back({CNT_W'(nd), CNT_W'(np)});
        for (int k = 0; k < ty.size(); k++) begin
            ival = 1;
            isop = (k == 0);
            isof = (k == 0) ? sof : 1'b0;
            iindex_M = (k == 0) ? m : 3'($urandom);
            iindex_ss = (k == 0) ? ss : 4'($urandom);
            iindex_subc = ty[k];
            isubc_i = ci[k];
            isubc_q = cq[k];
            @(posedge clk);
            #1;
        end
        if (gap) begin
            ival = 0;
            isop = 0;
            iindex_subc = 0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_dat.size() + exp_pil.size() + exp_sym.size()) != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(exp_dat.size() + exp_pil.size() + exp_sym.size()), 64'd0);
    endtask

    initial begin
        // reset state
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dat_val", odat_val, 0);
        chk("rst_pil_val", opil_val, 0);
        chk("rst_done", osym_done, 0);
        chk("rst_ovf", oovf, 0);
        chk("rst_cnts", {odata_cnt, opil_cnt}, 0);
        rst = 0;
        // carriers with no open symbol are ignored
        ival = 1;
        isop = 0;
        iindex_subc = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        iindex_subc = 2'd2;
        @(posedge clk);
        #1;
        ival = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_dat", odat_val, 0);
        chk("stray_done", osym_done, 0);
        // 1: mixed symbol
        ty = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
        send_sym(1, 3'd3, 4'd5, 1);
        drain("t1_drain");
        // 2: back-to-back symbols with different M/ss
        ty = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1};
        send_sym(0, 3'd2, 4'd9, 0);
        ty = '{2'd1, 2'd1, 2'd2, 2'd1};
        send_sym(1, 3'd5, 4'd3, 1);
        drain("t2_drain");
        // single data carrier then only pilots/nulls
        ty = '{2'd2, 2'd1, 2'd0};
        send_sym(0, 3'd7, 4'd15, 1);
        ty = '{2'd2, 2'd0, 2'd2, 2'd3, 2'd0};
        send_sym(0, 3'd1, 4'd1, 1);
        drain("t3_drain");
        // 4: overflow of the depth-8 instance
        rdy8 = 0;
        ty.delete();
        for (int k = 0; k < 12; k++) ty.push_back(2'd1);
        send_sym(0, 3'd4, 4'd7, 1);
        drain("t4_drain");
        chk("t4_ovf8", oovf8, 1);
        chk("t4_ovf", oovf, 0);
        chk("t4_val8", odat_val8, 1);
        rdy8 = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4_pop8", {odat_i8, odat_q8, odat_sos8, odat_eos8, odat_sof8, odat_M8, odat_ss8}, sym_dat[k]);
        end
        @(negedge clk);
        chk("t4_empty8", odat_val8, 0);
        @(posedge clk);
        #1;
        // 5: random backpressure, long symbols
        rnd_rdy = 1;
        for (int s = 0; s < 3; s++) begin
            ty.delete();
            for (int k = 0; k < 400; k++) ty.push_back(2'($urandom_range(0, 3)));
            send_sym(1'(s == 0), 3'($urandom), 4'($urandom), 1);
        end
        drain("t5_drain");
        rnd_rdy = 0;
        @(posedge clk);
        #1;
        odat_rdy = 1;
        chk("t5_ovf", oovf, 0);
        // 6: reset in the middle of a symbol
        odat_rdy = 0;
        for (int k = 0; k < 5; k++) begin
            ival = 1;
            isop = (k == 0);
            iindex_subc = 2'd1;
            iindex_M = 3'd6;
            isubc_i = DW'(k + 1);
            @(posedge clk);
            #1;
        end
        rst = 1;
        ival = 0;
        isop = 0;
        @(posedge clk);
        #1;
        chk("t6_dat_val", odat_val, 0);
        chk("t6_dat_i", odat_i, 0);
        chk("t6_pil", {opil_val, opil_i, opil_idx}, 0);
        chk("t6_done", {osym_done, odata_cnt, opil_cnt}, 0);
        chk("t6_ovf", {oovf, oovf8}, 0);
        rst = 0;
        odat_rdy = 1;
        ty = '{2'd0, 2'd1, 2'd1, 2'd2};
        send_sym(1, 3'd6, 4'd2, 1);
        drain("t6_drain");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
